// File: rtl/excitation_sched.sv
// LPC excitation scheduler: takes one frame of parameters at a time through a
// shadow register and emits one pulse or noise excitation sample per sample tick.
module excitation_sched #(
    parameter int          FRAME_LEN = 160,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               smp_tick,
    input  logic               frm_valid,
    output logic               frm_ready,
    input  logic               frm_voiced,
    input  logic        [15:0] frm_pitch,
    input  logic signed [15:0] frm_gain,
    output logic signed [15:0] exc_out,
    output logic               exc_vout,
    output logic               frame_start,
    output logic               underrun,
    output logic               fsm_state
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    state_t state, state_nx;

    logic               sh_full, sh_voiced;
    logic        [15:0] sh_pitch;
    logic signed [15:0] sh_gain;
    logic               act_voiced;
    logic        [15:0] act_pitch;
    logic signed [15:0] act_gain;
    logic        [15:0] pcnt, lfsr, idx;

    logic               hs, do_emit, load_sh, load_direct, do_load, set_underrun;
    logic               ld_voiced, ld_veff, cur_voiced, pulse;
    logic        [15:0] ld_pitch, cur_pitch, pc_cur, pcnt_nx, lfsr_nx;
    logic signed [15:0] ld_gain, cur_gain, neg_gain, sample;
    logic signed [16:0] rb;

    // Frame handshake: a frame transfers on any cycle with frm_valid and frm_ready high.
    assign frm_ready = ~sh_full;
    assign hs        = frm_valid & ~sh_full;
    assign do_load   = load_sh | load_direct;
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        do_emit      = 1'b0;
        load_sh      = 1'b0;
        load_direct  = 1'b0;
        set_underrun = 1'b0;
        if (smp_tick) begin
            unique case (state)
                IDLE: begin
                    if (sh_full) begin
                        state_nx = RUN;
                        load_sh  = 1'b1;
                        do_emit  = 1'b1;
                    end
                end
                RUN: begin
                    if (idx == LAST_IDX) begin
                        if (sh_full) begin
                            load_sh = 1'b1;
                            do_emit = 1'b1;
                        end else if (frm_valid) begin
                            load_direct = 1'b1;
                            do_emit     = 1'b1;
                        end else begin
                            set_underrun = 1'b1;
                            state_nx     = IDLE;
                        end
                    end else begin
                        do_emit = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ld_voiced = load_sh ? sh_voiced : frm_voiced;
        ld_pitch  = load_sh ? sh_pitch  : frm_pitch;
        ld_gain   = load_sh ? sh_gain   : frm_gain;
        ld_veff   = ld_voiced && (ld_pitch != 16'd0);
        rb        = $signed({1'b0, pcnt}) + $signed({1'b0, ld_pitch}) - $signed({1'b0, act_pitch});
        pc_cur    = pcnt;
        if (do_load) begin
            cur_voiced = ld_veff;
            cur_pitch  = ld_pitch;
            cur_gain   = ld_gain;
            // Voiced-to-voiced: keep the elapsed time since the last pulse, rebased to the new period.
            if (ld_veff && act_voiced && state == RUN) begin
                if (rb[16])                            pc_cur = 16'd0;
                else if (rb[15:0] > ld_pitch - 16'd1)  pc_cur = ld_pitch - 16'd1;
                else                                   pc_cur = rb[15:0];
            end else begin
                pc_cur = 16'd0;
            end
        end else begin
            cur_voiced = act_voiced;
            cur_pitch  = act_pitch;
            cur_gain   = act_gain;
        end
        neg_gain = (cur_gain == 16'sh8000) ? 16'sh7FFF : -cur_gain;
        pulse    = (pc_cur == 16'd0);
        pcnt_nx  = pc_cur;
        lfsr_nx  = lfsr;
        sample   = 16'sd0;
        if (cur_voiced) begin
            if (pulse) begin
                sample  = cur_gain;
                pcnt_nx = cur_pitch - 16'd1;
            end else begin
                pcnt_nx = pc_cur - 16'd1;
            end
        end else begin
            sample  = lfsr[0] ? cur_gain : neg_gain;
            lfsr_nx = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_full     <= 1'b0;
            sh_voiced   <= 1'b0;
            sh_pitch    <= 16'd0;
            sh_gain     <= 16'sd0;
            act_voiced  <= 1'b0;
            act_pitch   <= 16'd0;
            act_gain    <= 16'sd0;
            pcnt        <= 16'd0;
            lfsr        <= LFSR_SEED;
            idx         <= 16'd0;
            exc_out     <= 16'sd0;
            exc_vout    <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            // A boundary race consumes the incoming frame directly, bypassing the shadow.
            if (!load_direct && hs) begin
                sh_full   <= 1'b1;
                sh_voiced <= frm_voiced;
                sh_pitch  <= frm_pitch;
                sh_gain   <= frm_gain;
            end else if (load_sh) begin
                sh_full <= 1'b0;
            end
            if (do_load) begin
                act_voiced <= ld_veff;
                act_pitch  <= ld_pitch;
                act_gain   <= ld_gain;
            end
            if (do_emit) begin
                idx  <= do_load ? 16'd0 : idx + 16'd1;
                pcnt <= pcnt_nx;
                lfsr <= lfsr_nx;
            end
            exc_vout    <= do_emit;
            exc_out     <= do_emit ? sample : 16'sd0;
            frame_start <= do_emit & do_load;
            underrun    <= underrun | set_underrun;
        end
    end

endmodule

// File: tb/tb_excitation_sched.sv
// Directed bench for excitation_sched with FRAME_LEN=8: pulse trains, pitch carry,
// underrun, boundary race, saturating noise and asynchronous reset.
module tb_excitation_sched;

    logic               clk = 1'b0;
    logic               rst, smp_tick, frm_valid, frm_ready, frm_voiced;
    logic        [15:0] frm_pitch;
    logic signed [15:0] frm_gain, exc_out;
    logic               exc_vout, frame_start, underrun, fsm_state;

    int n_checks = 0;
    int n_pass   = 0;

    excitation_sched #(.FRAME_LEN(8), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .smp_tick(smp_tick), .frm_valid(frm_valid),
        .frm_ready(frm_ready), .frm_voiced(frm_voiced), .frm_pitch(frm_pitch),
        .frm_gain(frm_gain), .exc_out(exc_out), .exc_vout(exc_vout),
        .frame_start(frame_start), .underrun(underrun), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic signed [15:0] neg_sat(input logic signed [15:0] g);
        return (g == -16'sd32768) ? 16'sd32767 : -g;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; smp_tick = 1'b0; frm_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_frame(input logic v, input logic [15:0] p, input logic signed [15:0] g);
        @(negedge clk);
        frm_valid = 1'b1; frm_voiced = v; frm_pitch = p; frm_gain = g;
        for (int n = 0; n < 20 && frm_ready !== 1'b1; n++) @(negedge clk);
        check("push_ready", frm_ready, 1);
        @(negedge clk);
        frm_valid = 1'b0;
    endtask

    // One tick every 4 cycles; outputs sampled on the negedge after the tick edge.
    task automatic tick(output logic v, output logic signed [15:0] o, output logic fs);
        @(negedge clk);
        smp_tick = 1'b1;
        @(negedge clk);
        smp_tick = 1'b0;
        v = exc_vout; o = exc_out; fs = frame_start;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic race_tick(input logic fv, input logic [15:0] fp, input logic signed [15:0] fg,
                             output logic v, output logic signed [15:0] o, output logic fs);
        @(negedge clk);
        smp_tick = 1'b1; frm_valid = 1'b1; frm_voiced = fv; frm_pitch = fp; frm_gain = fg;
        @(negedge clk);
        smp_tick = 1'b0; frm_valid = 1'b0;
        v = exc_vout; o = exc_out; fs = frame_start;
        @(negedge clk);
    endtask

    initial begin
        logic v, fs;
        logic signed [15:0] o, e, g;
        logic [15:0] lm;
        int exp_a[8];
        int exp_c[17];

        rst = 1'b0; smp_tick = 1'b0; frm_valid = 1'b0;
        frm_voiced = 1'b0; frm_pitch = 16'd0; frm_gain = 16'sd0;
        #1 rst = 1'b1;
        #2;
        check("rst_ready", frm_ready, 1);
        check("rst_vout", exc_vout, 0);
        check("rst_out", exc_out, 0);
        check("rst_fs", frame_start, 0);
        check("rst_underrun", underrun, 0);
        check("rst_state", fsm_state, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Ticks in IDLE with no frame are ignored
        tick(v, o, fs);
        check("idle_vout", v, 0);

        // Voiced pitch 3, gain 1000, then underrun
        exp_a = '{1000, 0, 0, 1000, 0, 0, 1000, 0};
        push_frame(1'b1, 16'd3, 16'sd1000);
        for (int i = 0; i < 8; i++) begin
            tick(v, o, fs);
            e = 16'(exp_a[i]);
            check($sformatf("voiced_vout[%0d]", i), v, 1);
            check($sformatf("voiced_out[%0d]", i), o, e);
            check($sformatf("voiced_fs[%0d]", i), fs, (i == 0) ? 1 : 0);
        end
        check("pre_underrun", underrun, 0);
        tick(v, o, fs);
        check("ur_vout9", v, 0);
        check("ur_flag", underrun, 1);
        check("ur_state", fsm_state, 0);
        tick(v, o, fs);
        check("ur_vout10", v, 0);
        check("ur_sticky", underrun, 1);

        // Pitch carry across voiced frames: pulses at 0,3,6 then 11,16
        do_reset();
        check("reset_clears_ur", underrun, 0);
        for (int i = 0; i < 17; i++) exp_c[i] = 0;
        exp_c[0] = 1000; exp_c[3] = 1000; exp_c[6] = 1000; exp_c[11] = 500; exp_c[16] = 500;
        push_frame(1'b1, 16'd3, 16'sd1000);
        for (int i = 0; i < 17; i++) begin
            tick(v, o, fs);
            e = 16'(exp_c[i]);
            check($sformatf("carry_vout[%0d]", i), v, 1);
            check($sformatf("carry_out[%0d]", i), o, e);
            check($sformatf("carry_fs[%0d]", i), fs, (i == 0 || i == 8 || i == 16) ? 1 : 0);
            if (i == 0) push_frame(1'b1, 16'd5, 16'sd500);
            if (i == 8) push_frame(1'b1, 16'd5, 16'sd500);
        end
        check("carry_underrun", underrun, 0);

        // Boundary race: new frame arrives on the boundary tick with the shadow empty
        do_reset();
        push_frame(1'b1, 16'd3, 16'sd1000);
        for (int i = 0; i < 8; i++) tick(v, o, fs);
        race_tick(1'b1, 16'd2, 16'sd700, v, o, fs);
        check("race_vout", v, 1);
        check("race_out", o, 700);
        check("race_fs", fs, 1);
        check("race_underrun", underrun, 0);
        tick(v, o, fs);
        check("race_out1", o, 0);
        tick(v, o, fs);
        check("race_out2", o, 700);

        // Saturating noise, then voiced with pitch 0 behaving as noise
        do_reset();
        lm = 16'hACE1;
        push_frame(1'b0, 16'd7, -16'sd32768);
        for (int i = 0; i < 16; i++) begin
            tick(v, o, fs);
            g = (i < 8) ? -16'sd32768 : 16'sd1234;
            e = lm[0] ? g : neg_sat(g);
            lm = lfsr_step(lm);
            check($sformatf("noise_vout[%0d]", i), v, 1);
            check($sformatf("noise_out[%0d]", i), o, e);
            if (i == 0) push_frame(1'b1, 16'd0, 16'sd1234);
        end
        check("noise_underrun", underrun, 0);

        // Asynchronous reset between clock edges, mid-frame with a shadow frame held
        do_reset();
        push_frame(1'b1, 16'd3, 16'sd1000);
        tick(v, o, fs);
        push_frame(1'b1, 16'd4, 16'sd800);
        tick(v, o, fs);
        tick(v, o, fs);
        check("arst_pre_ready", frm_ready, 0);
        @(negedge clk);
        smp_tick = 1'b1;
        @(posedge clk);
        #2;
        check("arst_pre_vout", exc_vout, 1);
        check("arst_pre_out", exc_out, 1000);
        rst = 1'b1;
        #1;
        check("arst_vout", exc_vout, 0);
        check("arst_out", exc_out, 0);
        check("arst_ready", frm_ready, 1);
        check("arst_state", fsm_state, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        smp_tick = 1'b0;
        tick(v, o, fs);
        check("arst_shadow_gone", v, 0);
        push_frame(1'b1, 16'd3, 16'sd900);
        tick(v, o, fs);
        check("arst_restart_vout", v, 1);
        check("arst_restart_out", o, 900);
        check("arst_restart_fs", fs, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/excitation_sched.md
EXCITATION_SCHED -- requirements
Module: excitation_sched

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter FRAME_LEN, default 160, giving the number of samples per LPC frame (range 2..65535).
REQ-002 The block SHALL have parameter LFSR_SEED, default 16'hACE1, giving the noise LFSR reset/reload value (must be nonzero).
Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes occur on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 The block SHALL have port smp_tick, input, 1, a one-cycle sample-rate strobe.
REQ-006 The block SHALL have port frm_valid, input, 1, frame parameters are present.
REQ-007 The block SHALL have port frm_ready, output, 1, the block can accept a frame.
REQ-008 The block SHALL have port frm_voiced, input, 1, 1 selects pulse excitation and 0 selects noise.
REQ-009 The block SHALL have port frm_pitch, input, 16 unsigned, the pitch period in samples.
REQ-010 The block SHALL have port frm_gain, input, 16 signed, the excitation amplitude.
REQ-011 The block SHALL have port exc_out, output, 16 signed, the excitation sample.
REQ-012 The block SHALL have port exc_vout, output, 1, exc_out is valid for one cycle.
REQ-013 The block SHALL have port frame_start, output, 1, a pulse coincident with exc_vout of sample 0 of each frame.
REQ-014 The block SHALL have port underrun, output, 1, sticky; set when no frame is available at a frame boundary.

Function
REQ-015 The block SHALL complete a frame handshake on a cycle where frm_valid and frm_ready are both 1, capturing voiced, pitch and gain into the shadow register.
REQ-016 frm_ready SHALL equal 1 exactly when the shadow register is empty (combinational from the shadow-full flag).
REQ-017 The FSM SHALL have two states, IDLE and RUN; in IDLE, smp_tick is ignored and exc_vout stays 0.
REQ-018 The FSM SHALL move from IDLE to RUN on the first smp_tick while the shadow is full; at that tick the shadow moves to the active registers, the shadow empties, and the sample index becomes 0.
REQ-019 In RUN, each smp_tick SHALL produce one sample; exc_out and exc_vout SHALL be registered and valid on the cycle after smp_tick (latency 1).
REQ-020 Samples with index 0..FRAME_LEN-1 SHALL use the active frame's parameters; the tick after index FRAME_LEN-1 is a frame boundary.
REQ-021 At a frame boundary with the shadow full, the shadow SHALL move to active, the shadow SHALL empty, and index 0 SHALL be emitted on that same tick.
REQ-022 At a frame boundary with the shadow empty, the block SHALL set underrun, return to IDLE, and emit no sample for that tick.
REQ-023 A handshake occurring in the same cycle as a boundary tick with the shadow empty SHALL load the new frame directly to active, emit index 0, and not set underrun.
REQ-024 Voiced mode (voiced=1, pitch>=1): the pitch counter SHALL emit exc_out=gain when it equals 0 and then reload pitch-1; otherwise it emits 0 and decrements.
REQ-025 The pitch counter SHALL carry across consecutive voiced frames; if the counter exceeds the new pitch-1 on load, it SHALL be clamped to pitch-1.
REQ-026 Entering voiced mode from IDLE or from an unvoiced frame SHALL set the pitch counter to 0, so a pulse is emitted on the first voiced sample.
REQ-027 A frame with voiced=1 and pitch=0 SHALL be treated as unvoiced.
REQ-028 Unvoiced mode: the 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance once per emitted sample; exc_out SHALL be gain when the LFSR bit 0 is 1, and -gain otherwise.
REQ-029 Negation SHALL saturate: -(-32768) = 32767.
REQ-030 smp_tick SHALL be assumed to be at most one cycle in two; if ticks arrive back-to-back, each tick still produces exactly one sample.

Reset
REQ-031 While rst=1, the block SHALL hold state=IDLE, shadow empty, active registers 0, pitch counter 0, LFSR=LFSR_SEED, sample index 0, exc_out=0, exc_vout=0, frame_start=0, and underrun=0.
REQ-032 While rst=1, frm_ready SHALL be 1.
REQ-033 A reset asserted mid-frame SHALL abort the frame immediately, discard any shadow frame, and clear underrun.

Verification
REQ-034 Voiced pulses: FRAME_LEN=8, frame voiced=1, pitch=3, gain=1000, ticks every 4 cycles -> exc_out = 1000,0,0,1000,0,0,1000,0; frame_start on the first sample only.
REQ-035 Pitch carry: a voiced pitch=3 frame followed by a voiced pitch=5 frame, loaded early -> pulses at global sample indices 0,3,6, then 11 and 16, with no gap at the boundary and no underrun.
REQ-036 Underrun: a single frame and 10 ticks with FRAME_LEN=8 -> 8 samples, underrun=1 at the 9th tick, the 9th and 10th ticks produce no exc_vout, and the state is IDLE.
REQ-037 Noise saturation: unvoiced, gain=-32768, LFSR_SEED=16'hACE1 -> every exc_out is -32768 or 32767, and the sequence matches a reference LFSR model.
REQ-038 Boundary race: frm_valid is asserted exactly on the boundary tick with the shadow empty -> index 0 of the new frame is emitted and underrun stays 0.
REQ-039 Async reset: rst pulsed mid-frame, between clock edges -> outputs are 0 and frm_ready=1 before the next clk edge; the next frame restarts with index 0 and a voiced pulse.
